// File: rtl/capture_pkg.sv
// capture_pkg: shared constants for the input-capture FIFO.
//   Entry layout  : {sat, edge, count_high[31:0], count_low[31:0]} = 66 bits
//   DefaultDepth  : default number of stored entries
//   DropW         : width of the saturating drop counter
//   sat_inc()     : saturating increment for the drop counter
package capture_pkg;

    localparam int unsigned EntryW       = 66;
    localparam int unsigned CountW       = 64;
    localparam int unsigned LowLsb       = 0;
    localparam int unsigned HighLsb      = 32;
    localparam int unsigned EdgeBit      = 64;
    localparam int unsigned SatBit       = 65;
    localparam int unsigned DefaultDepth = 16;
    localparam int unsigned DropW        = 16;

    localparam logic [DropW-1:0] DropMax = '1;
    localparam logic [DropW-1:0] DropOne = {{(DropW-1){1'b0}}, 1'b1};

    function automatic logic [DropW-1:0] sat_inc(input logic [DropW-1:0] v);
        return (v == DropMax) ? v : v + DropOne;
    endfunction

endpackage

// File: rtl/capture_fifo_mem.sv
// capture_fifo_mem: DEPTH x EntryW storage array, one synchronous write port and
// one asynchronous read port. No reset; contents are only meaningful where the
// owning FIFO's pointers say so.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module capture_fifo_mem
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [EntryW-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [EntryW-1:0] o_rdata
);

    logic [EntryW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through FIFO for input-capture timer results.
//   Clk, Reset_n            : clock, synchronous active-low reset
//   Cap_Valid/Low/High/Edge/Sat : capture result pulse and its fields
//   Flush                   : discard all stored entries (overrun state kept)
//   Out_Valid/Ready         : head handshake; Out_Count/Edge/Sat show the head
//   Level                   : number of stored entries, 0..DEPTH
//   Irq_Enable/Threshold, Irq : registered level interrupt
//   Overrun, Overrun_Clr, Drop_Count : dropped-capture reporting
module capture_fifo
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Cap_Valid,
    input  logic [31:0]       Cap_Low,
    input  logic [31:0]       Cap_High,
    input  logic              Cap_Edge,
    input  logic              Cap_Sat,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CountW-1:0] Out_Count,
    output logic              Out_Edge,
    output logic              Out_Sat,
    output logic [LW-1:0]     Level,
    input  logic              Irq_Enable,
    input  logic [LW-1:0]     Irq_Threshold,
    output logic              Irq,
    output logic              Overrun,
    input  logic              Overrun_Clr,
    output logic [DropW-1:0]  Drop_Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]     w_wr_ptr_d, w_rd_ptr_d;
    logic [PW-1:0]     w_level, w_level_d;
    logic              r_irq, w_irq_d;
    logic              r_overrun, w_overrun_d;
    logic [DropW-1:0]  r_drop_cnt, w_drop_cnt_d;
    logic              w_empty, w_full;
    logic              w_rd, w_wr, w_drop;
    logic [LW-1:0]     w_thr_eff;
    logic [EntryW-1:0] w_wdata, w_rdata;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    // A read on a full FIFO frees the slot, so the write is not a drop.
    // Drop detection ignores Flush: a capture lost while full is still reported.
    assign w_rd   = !w_empty && Out_Ready;
    assign w_drop = Cap_Valid && w_full && !w_rd;
    assign w_wr   = Cap_Valid && !w_drop && !Flush;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        if (Flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            if (w_wr) begin
                w_wr_ptr_d = r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                w_rd_ptr_d = r_rd_ptr + PW'(1);
            end
        end
    end

    assign w_level_d = w_wr_ptr_d - w_rd_ptr_d;

    // Threshold 0 behaves as 1 so an empty FIFO never raises the interrupt.
    assign w_thr_eff = (Irq_Threshold == '0) ? LW'(1) : Irq_Threshold;
    assign w_irq_d   = Irq_Enable && (32'(w_level_d) >= 32'(w_thr_eff));

    // Same-cycle drop beats clear: the counter restarts at one.
    always_comb begin
        w_overrun_d  = r_overrun;
        w_drop_cnt_d = r_drop_cnt;
        if (w_drop) begin
            w_overrun_d  = 1'b1;
            w_drop_cnt_d = Overrun_Clr ? DropOne : sat_inc(r_drop_cnt);
        end else if (Overrun_Clr) begin
            w_overrun_d  = 1'b0;
            w_drop_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_irq      <= 1'b0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_irq      <= w_irq_d;
            r_overrun  <= w_overrun_d;
            r_drop_cnt <= w_drop_cnt_d;
        end
    end

    assign w_wdata = {Cap_Sat, Cap_Edge, Cap_High, Cap_Low};

    capture_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (Clk),
        .i_we    (w_wr && Reset_n),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Head fields are forced to zero while nothing is stored.
    assign Out_Valid  = !w_empty;
    assign Out_Count  = Out_Valid ? w_rdata[HighLsb+31:LowLsb] : '0;
    assign Out_Edge   = Out_Valid ? w_rdata[EdgeBit] : 1'b0;
    assign Out_Sat    = Out_Valid ? w_rdata[SatBit] : 1'b0;
    assign Level      = LW'(w_level);
    assign Irq        = r_irq;
    assign Overrun    = r_overrun;
    assign Drop_Count = r_drop_cnt;

endmodule
